// File: rtl/traffic_pkg.sv
// Shared phase/config codes and phase-sequencing rule for the traffic light bank.
package traffic_pkg;

    // Widest duration the sequencing helper accepts; channels zero-extend into it.
    localparam int FN_TIME_W = 16;

    typedef enum logic [1:0] {
        PH_OFF    = 2'd0,
        PH_RED    = 2'd1,
        PH_GREEN  = 2'd2,
        PH_YELLOW = 2'd3
    } phase_t;

    typedef enum logic [1:0] {
        CF_RED    = 2'd0,
        CF_GREEN  = 2'd1,
        CF_YELLOW = 2'd2,
        CF_START  = 2'd3
    } cfg_field_t;

    // First successor in RED->GREEN->YELLOW order with a non-zero time; else stay put.
    function automatic phase_t next_phase(
        input phase_t                 cur,
        input logic [FN_TIME_W-1:0]   t_red,
        input logic [FN_TIME_W-1:0]   t_green,
        input logic [FN_TIME_W-1:0]   t_yel,
        input logic                   yellow_en
    );
        logic   ok_r;
        logic   ok_g;
        logic   ok_y;
        phase_t nxt;
        ok_r = (t_red != '0);
        ok_g = (t_green != '0);
        ok_y = yellow_en && (t_yel != '0);
        nxt  = cur;
        case (cur)
            PH_RED:    if (ok_g) nxt = PH_GREEN;  else if (ok_y) nxt = PH_YELLOW;
            PH_GREEN:  if (ok_y) nxt = PH_YELLOW; else if (ok_r) nxt = PH_RED;
            PH_YELLOW: if (ok_r) nxt = PH_RED;    else if (ok_g) nxt = PH_GREEN;
            default:   nxt = cur;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/traffic_light_chan.sv
// One traffic-light channel: programmable phase times, start phase, phase FSM,
// tick counter and the registered phase_done pulse.
module traffic_light_chan
    import traffic_pkg::*;
#(
    parameter int TIME_W       = 5,
    parameter int DEFAULT_TIME = 10,
    parameter bit YELLOW_EN    = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_tick,
    input  logic              i_run,
    input  logic              i_restart,
    input  logic              i_cfg_we,
    input  cfg_field_t        i_cfg_field,
    input  logic [TIME_W-1:0] i_cfg_data,
    output logic [1:0]        o_color,
    output logic              o_phase_done
);

    logic [TIME_W-1:0] r_time_red,  w_time_red;
    logic [TIME_W-1:0] r_time_grn,  w_time_grn;
    logic [TIME_W-1:0] r_time_yel,  w_time_yel;
    phase_t            r_start,     w_start;
    phase_t            r_phase,     w_phase;
    logic [TIME_W-1:0] r_count,     w_count;
    logic              r_done,      w_done;

    logic [TIME_W-1:0] w_cur_time;
    logic              w_terminal;
    phase_t            w_succ;
    phase_t            w_cfg_start;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_time_red <= TIME_W'(DEFAULT_TIME);
            r_time_grn <= TIME_W'(DEFAULT_TIME);
            r_time_yel <= TIME_W'(DEFAULT_TIME);
            r_start    <= PH_RED;
            r_phase    <= PH_RED;
            r_count    <= '0;
            r_done     <= 1'b0;
        end else begin
            r_time_red <= w_time_red;
            r_time_grn <= w_time_grn;
            r_time_yel <= w_time_yel;
            r_start    <= w_start;
            r_phase    <= w_phase;
            r_count    <= w_count;
            r_done     <= w_done;
        end
    end

    always_comb begin
        case (r_phase)
            PH_GREEN:  w_cur_time = r_time_grn;
            PH_YELLOW: w_cur_time = r_time_yel;
            default:   w_cur_time = r_time_red;
        endcase
    end

    // Extra bit keeps count+1 from wrapping when the time is at its maximum.
    assign w_terminal = ({1'b0, r_count} + (TIME_W+1)'(1)) >= {1'b0, w_cur_time};
    assign w_succ     = next_phase(r_phase, FN_TIME_W'(r_time_red), FN_TIME_W'(r_time_grn),
                                   FN_TIME_W'(r_time_yel), YELLOW_EN);
    assign w_cfg_start = ((i_cfg_data[1:0] == 2'd0) || (i_cfg_data[1:0] == 2'd3 && !YELLOW_EN))
                         ? PH_RED : phase_t'(i_cfg_data[1:0]);

    always_comb begin
        w_time_red = r_time_red;
        w_time_grn = r_time_grn;
        w_time_yel = r_time_yel;
        w_start    = r_start;
        w_phase    = r_phase;
        w_count    = r_count;
        w_done     = 1'b0;
        if (i_restart) begin
            w_phase = r_start;
            w_count = '0;
        end else if (i_cfg_we) begin
            // A write to this channel swallows any tick in the same cycle.
            case (i_cfg_field)
                CF_RED:    w_time_red = i_cfg_data;
                CF_GREEN:  w_time_grn = i_cfg_data;
                CF_YELLOW: if (YELLOW_EN) w_time_yel = i_cfg_data;
                CF_START: begin
                    w_start = w_cfg_start;
                    w_phase = w_cfg_start;
                    w_count = '0;
                end
                default: ;
            endcase
        end else if (i_run && i_tick) begin
            if (w_terminal) begin
                w_count = '0;
                w_phase = w_succ;
                w_done  = (w_succ != r_phase);
            end else begin
                w_count = r_count + TIME_W'(1);
            end
        end
    end

    assign o_color      = i_run ? r_phase : PH_OFF;
    assign o_phase_done = r_done;

endmodule

// File: rtl/traffic_light_bank.sv
// N-channel programmable traffic-light controller: config decode, control
// fan-out and output packing around an array of channels.
module traffic_light_bank
    import traffic_pkg::*;
#(
    parameter int NUM_LIGHTS   = 4,
    parameter int TIME_W       = 5,
    parameter int DEFAULT_TIME = 10,
    parameter bit YELLOW_EN    = 1'b1,
    localparam int LIGHT_W     = (NUM_LIGHTS > 1) ? $clog2(NUM_LIGHTS) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    tick,
    input  logic                    run,
    input  logic                    restart,
    input  logic                    cfg_valid,
    input  logic [LIGHT_W-1:0]      cfg_light,
    input  logic [1:0]              cfg_field,
    input  logic [TIME_W-1:0]       cfg_data,
    output logic [2*NUM_LIGHTS-1:0] color,
    output logic [NUM_LIGHTS-1:0]   phase_done
);

    logic [NUM_LIGHTS-1:0]      w_cfg_we;
    logic [NUM_LIGHTS-1:0][1:0] w_color;
    cfg_field_t                 w_cfg_field;

    assign w_cfg_field = cfg_field_t'(cfg_field);

    // Out-of-range cfg_light matches no channel, so the write is dropped.
    for (genvar g = 0; g < NUM_LIGHTS; g++) begin : g_chan
        assign w_cfg_we[g] = cfg_valid && (cfg_light == LIGHT_W'(g));

        traffic_light_chan #(
            .TIME_W       (TIME_W),
            .DEFAULT_TIME (DEFAULT_TIME),
            .YELLOW_EN    (YELLOW_EN)
        ) u_chan (
            .clk          (clk),
            .rst          (rst),
            .i_tick       (tick),
            .i_run        (run),
            .i_restart    (restart),
            .i_cfg_we     (w_cfg_we[g]),
            .i_cfg_field  (w_cfg_field),
            .i_cfg_data   (cfg_data),
            .o_color      (w_color[g]),
            .o_phase_done (phase_done[g])
        );
    end

    assign color = w_color;

endmodule

// File: tb/tb_traffic_light_bank.sv
// Bench for traffic_light_bank: directed table/sequences plus random stimulus
// against an index-based reference model of the channel rules.
module tb_traffic_light_bank;

    localparam int NL  = 4;
    localparam int TW  = 5;
    localparam int DEF = 10;
    localparam bit YEN = 1'b1;

    logic            clk = 1'b0;
    logic            rst, tick, run, restart, cfg_valid;
    logic [1:0]      cfg_light, cfg_field;
    logic [TW-1:0]   cfg_data;
    logic [2*NL-1:0] color;
    logic [NL-1:0]   phase_done;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: phase index 0=RED 1=GREEN 2=YELLOW, lamp code = index+1.
    int m_tm [NL][3];
    int m_st [NL];
    int m_ph [NL];
    int m_cnt[NL];
    bit m_dn [NL];
    int pulses[NL];
    bit saw_y2;

    typedef struct {
        int ticks;
        int col;
        int done;
        int pulses;
    } vec_t;
    vec_t tbl[5];

    traffic_light_bank #(
        .NUM_LIGHTS(NL), .TIME_W(TW), .DEFAULT_TIME(DEF), .YELLOW_EN(YEN)
    ) dut (
        .clk(clk), .rst(rst), .tick(tick), .run(run), .restart(restart),
        .cfg_valid(cfg_valid), .cfg_light(cfg_light), .cfg_field(cfg_field),
        .cfg_data(cfg_data), .color(color), .phase_done(phase_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int chan_color(input int ch);
        return int'(color[2*ch +: 2]);
    endfunction

    function automatic int m_next(input int ch);
        int c;
        for (int k = 1; k <= 2; k++) begin
            c = (m_ph[ch] + k) % 3;
            if (!(c == 2 && !YEN) && m_tm[ch][c] != 0) return c;
        end
        return m_ph[ch];
    endfunction

    task automatic model_step();
        int code;
        int nx;
        if (rst) begin
            for (int ch = 0; ch < NL; ch++) begin
                for (int p = 0; p < 3; p++) m_tm[ch][p] = DEF;
                m_st[ch] = 0; m_ph[ch] = 0; m_cnt[ch] = 0; m_dn[ch] = 0;
            end
            return;
        end
        for (int ch = 0; ch < NL; ch++) begin
            m_dn[ch] = 0;
            if (restart) begin
                m_ph[ch]  = m_st[ch];
                m_cnt[ch] = 0;
            end else if (cfg_valid && int'(cfg_light) == ch) begin
                if (cfg_field < 2'd3) begin
                    if (!(cfg_field == 2'd2 && !YEN)) m_tm[ch][int'(cfg_field)] = int'(cfg_data);
                end else begin
                    code = int'(cfg_data[1:0]);
                    m_st[ch]  = (code == 0 || (code == 3 && !YEN)) ? 0 : code - 1;
                    m_ph[ch]  = m_st[ch];
                    m_cnt[ch] = 0;
                end
            end else if (run && tick) begin
                if (m_cnt[ch] + 1 >= m_tm[ch][m_ph[ch]]) begin
                    nx = m_next(ch);
                    m_cnt[ch] = 0;
                    if (nx != m_ph[ch]) begin
                        m_ph[ch] = nx;
                        m_dn[ch] = 1;
                    end
                end else begin
                    m_cnt[ch]++;
                end
            end
        end
    endtask

    task automatic cycle();
        logic [2*NL-1:0] expc;
        logic [NL-1:0]   expd;
        @(posedge clk);
        model_step();
        #1;
        for (int ch = 0; ch < NL; ch++) begin
            expc[2*ch +: 2] = run ? 2'(m_ph[ch] + 1) : 2'b00;
            expd[ch]        = m_dn[ch];
            if (phase_done[ch]) pulses[ch]++;
        end
        if (color[5:4] == 2'b11) saw_y2 = 1'b1;
        check("model color", int'(color), int'(expc));
        check("model phase_done", int'(phase_done), int'(expd));
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            tick = 1'b0;
            repeat (3) cycle();
            tick = 1'b1;
            cycle();
            tick = 1'b0;
        end
    endtask

    task automatic cfg(input int l, input int f, input int d);
        cfg_valid = 1'b1;
        cfg_light = 2'(l);
        cfg_field = 2'(f);
        cfg_data  = TW'(d);
        cycle();
        cfg_valid = 1'b0;
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        cycle();
        restart = 1'b0;
    endtask

    initial begin
        int prev;
        int p;
        tbl[0] = '{ticks: 9,  col: 1, done: 0, pulses: 0};
        tbl[1] = '{ticks: 10, col: 2, done: 1, pulses: 1};
        tbl[2] = '{ticks: 19, col: 2, done: 0, pulses: 1};
        tbl[3] = '{ticks: 20, col: 3, done: 1, pulses: 2};
        tbl[4] = '{ticks: 30, col: 1, done: 1, pulses: 3};

        rst = 1'b1; run = 1'b0; tick = 1'b0; restart = 1'b0;
        cfg_valid = 1'b0; cfg_light = '0; cfg_field = '0; cfg_data = '0;
        for (int ch = 0; ch < NL; ch++) pulses[ch] = 0;
        saw_y2 = 1'b0;

        cycle();
        check("reset run0 color", int'(color), 0);
        run = 1'b1;
        cycle();
        rst = 1'b0;
        check("reset color", int'(color), 8'h55);
        check("reset phase_done", int'(phase_done), 0);

        // Default sequence on ch0
        prev = 0;
        for (int i = 0; i < 5; i++) begin
            ticks(tbl[i].ticks - prev);
            prev = tbl[i].ticks;
            check("seq ch0 color", chan_color(0), tbl[i].col);
            check("seq ch0 done", int'(phase_done[0]), tbl[i].done);
            check("seq ch0 pulses", pulses[0], tbl[i].pulses);
        end

        // ch2 red 3 / green 5 / no yellow
        cfg(2, 0, 3); cfg(2, 1, 5); cfg(2, 2, 0);
        saw_y2 = 1'b0;
        ticks(3);
        check("ch2 green after 3", chan_color(2), 2);
        ticks(5);
        check("ch2 red after 8", chan_color(2), 1);
        check("ch0 unaffected", chan_color(0), 1);
        ticks(8);
        check("ch2 red after 16", chan_color(2), 1);
        check("ch2 never yellow", int'(saw_y2), 0);

        // ch1: zeroing the current (green) time forces an advance, then RED holds
        cfg(1, 1, 0); cfg(1, 2, 0);
        ticks(1);
        check("ch1 zero-time advance", chan_color(1), 1);
        check("ch1 zero-time done", int'(phase_done[1]), 1);
        p = pulses[1];
        ticks(25);
        check("ch1 holds red", chan_color(1), 1);
        check("ch1 no pulses", pulses[1] - p, 0);

        // start phase + restart
        cfg(3, 3, 2);
        check("ch3 start forced", chan_color(3), 2);
        pulse_restart();
        check("restart color", int'(color), 8'h95);
        check("restart done", int'(phase_done), 0);

        // run = 0 freeze mid-phase
        ticks(4);
        run = 1'b0;
        ticks(7);
        check("run0 color off", int'(color), 0);
        run = 1'b1;
        ticks(5);
        check("resume ch0 still red", chan_color(0), 1);
        ticks(1);
        check("resume ch0 green", chan_color(0), 2);
        check("resume ch0 done", int'(phase_done[0]), 1);

        // cfg vs terminal tick in the same cycle
        cfg(1, 1, 4); cfg(1, 0, 7);
        pulse_restart();
        ticks(6);
        tick = 1'b0; repeat (3) cycle();
        tick = 1'b1; cfg_valid = 1'b1; cfg_light = 2'd0; cfg_field = 2'd0; cfg_data = TW'(2);
        cycle();
        tick = 1'b0; cfg_valid = 1'b0;
        check("cfg-tick ch0 held", chan_color(0), 1);
        check("cfg-tick ch0 no done", int'(phase_done[0]), 0);
        check("cfg-tick ch1 advanced", chan_color(1), 2);
        check("cfg-tick ch1 done", int'(phase_done[1]), 1);
        ticks(1);
        check("reprog ch0 advance", chan_color(0), 2);
        check("reprog ch0 done", int'(phase_done[0]), 1);

        // rst mid-phase drops everything
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("mid rst color", int'(color), 8'h55);
        ticks(9);
        check("post rst ch0 red", chan_color(0), 1);
        ticks(1);
        check("post rst ch0 green", chan_color(0), 2);

        // random
        repeat (3000) begin
            rst       = ($urandom_range(399, 0) == 0);
            run       = ($urandom_range(7, 0) != 0);
            tick      = ($urandom_range(2, 0) == 0);
            restart   = ($urandom_range(59, 0) == 0);
            cfg_valid = ($urandom_range(5, 0) == 0);
            cfg_light = 2'($urandom_range(3, 0));
            cfg_field = 2'($urandom_range(3, 0));
            cfg_data  = ($urandom_range(3, 0) == 0) ? TW'($urandom_range(31, 0))
                                                   : TW'($urandom_range(4, 0));
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
